// File: rtl/inst_fetch_unit_if.sv
// Decoder-side handshake for the instruction fetch stage.
// master = fetch unit (drives word), slave = decoder (drives ready).
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 4
);
    logic              ir_valid;
    logic              ir_ready;
    logic [31:0]       ir_data;
    logic [ADDR_W-1:0] ir_pc;

    modport master (
        output ir_valid,
        output ir_data,
        output ir_pc,
        input  ir_ready
    );

    modport slave (
        input  ir_valid,
        input  ir_data,
        input  ir_pc,
        output ir_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: program memory, PC, prefetch FIFO, redirect flush.
// Optional halt-word detection is enabled by defining IFETCH_HALT_DET_EN.
module inst_fetch_unit #(
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    input  logic                         prog_we,
    input  logic [ADDR_W-1:0]            prog_addr,
    input  logic [31:0]                  prog_data,
    input  logic                         start,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    inst_fetch_unit_if.master            ir,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         halted
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef IFETCH_HALT_DET_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t state_q, state_d;

    logic [31:0]       imem [IMEM_DEPTH];
    logic [ADDR_W-1:0] pc_q;

    // single-stage read pipe: at most one read is ever in flight
    logic              rd_valid_q;
    logic [31:0]       rd_data_q;
    logic [ADDR_W-1:0] rd_pc_q;

    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              flush;
    logic              push;
    logic              pop;
    logic              issue;
    logic              halt_push;
    logic [CNT_W:0]    credit_used;

    assign flush = redirect_valid && (state_q != IDLE);
    assign push  = rd_valid_q && !flush;
    assign pop   = ir.ir_valid && ir.ir_ready && !flush;

    assign credit_used = {1'b0, count_q}
                       + {{CNT_W{1'b0}}, rd_valid_q};

    assign issue = (state_q == RUN) && !flush && !halt_push
                && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

`ifdef IFETCH_HALT_DET_EN
    assign halt_push = push && (rd_data_q[31:27] == 5'b11111);
    assign halted    = (state_q == HALT);
`else
    assign halt_push = 1'b0;
    assign halted    = 1'b0;
`endif

    assign ir.ir_valid = (count_q != '0);
    assign ir.ir_data  = fifo_data[rd_ptr_q];
    assign ir.ir_pc    = fifo_pc[rd_ptr_q];
    assign fifo_count  = count_q;

    // state register
    always_ff @(posedge clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next-state: start leaves IDLE, halt word parks, redirect resumes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
`ifdef IFETCH_HALT_DET_EN
            RUN:  if (halt_push) state_d = HALT;
            HALT: if (redirect_valid) state_d = RUN;
`else
            RUN:  state_d = RUN;
`endif
            default: state_d = state_q;
        endcase
    end

    // program load in IDLE and synchronous instruction read
    always_ff @(posedge clk) begin
        if (!sys_rst && prog_we && (state_q == IDLE))
            imem[prog_addr] <= prog_data;
        if (issue)
            rd_data_q <= imem[pc_q];
    end

    // PC, read tag, and prefetch FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pc_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (flush) begin
            pc_q       <= redirect_pc;
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if ((state_q == IDLE) && start)
                pc_q <= '0;
            rd_valid_q <= issue;
            if (issue) begin
                pc_q    <= pc_q + ADDR_W'(1);
                rd_pc_q <= pc_q;
            end
            if (push) begin
                fifo_data[wr_ptr_q] <= rd_data_q;
                fifo_pc[wr_ptr_q]   <= rd_pc_q;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: vector table, directed corner sequences,
// and random traffic against a queue-based fetch model.
module tb_inst_fetch_unit;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FD    = 4;
`ifdef IFETCH_HALT_DET_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          start;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          ready;
    logic [2:0]    fifo_count;
    logic          halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_unit_if #(.ADDR_W(AW)) irb ();
    assign irb.ir_ready = ready;

    inst_fetch_unit #(
        .IMEM_DEPTH(DEPTH),
        .ADDR_W(AW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .sys_rst(sys_rst),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .start(start),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .ir(irb.master),
        .fifo_count(fifo_count),
        .halted(halted)
    );

    // reference model: words waiting for the decoder, one pending read
    typedef struct {
        logic [31:0] d;
        int          pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_run = 0;
    bit          m_halt = 0;
    int          m_pc = 0;
    bit          m_if = 0;
    logic [31:0] m_if_d = '0;
    int          m_if_pc = 0;
    logic [31:0] m_imem [DEPTH];

    function automatic void model_step();
        int occ;
        bit iss;
        bit hit;
        if (sys_rst) begin
            m_run = 0; m_halt = 0; m_pc = 0; m_if = 0;
            mq.delete();
        end else if (redirect_valid && (m_run || m_halt)) begin
            mq.delete();
            m_if = 0;
            m_pc = int'(redirect_pc);
            m_run = 1; m_halt = 0;
        end else if (!m_run && !m_halt) begin
            if (prog_we) m_imem[prog_addr] = prog_data;
            if (start) begin m_run = 1; m_pc = 0; end
        end else begin
            occ = mq.size();
            iss = m_run && (occ + int'(m_if) < FD);
            hit = 0;
            if (occ > 0 && ready) void'(mq.pop_front());
            if (m_if) begin
                mq.push_back('{m_if_d, m_if_pc});
                hit = HALT_EN && (m_if_d[31:27] == 5'h1f);
            end
            if (hit) begin m_run = 0; m_halt = 1; iss = 0; end
            m_if = iss;
            if (iss) begin
                m_if_d  = m_imem[m_pc];
                m_if_pc = m_pc;
                m_pc    = (m_pc + 1) % DEPTH;
            end
        end
    endfunction

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endfunction

    function automatic void chk_model();
        chk("rnd_valid", 32'(irb.ir_valid), 32'(mq.size() > 0));
        chk("rnd_count", 32'(fifo_count), mq.size());
        chk("rnd_halted", 32'(halted), 32'(m_halt));
        if (mq.size() > 0) begin
            chk("rnd_pc", 32'(irb.ir_pc), mq[0].pc);
            chk("rnd_data", irb.ir_data, mq[0].d);
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          st;
        bit          rdy;
        bit          ev;
        int          epc;
        logic [31:0] edata;
        int          ecnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 32'h0, 0};
        tbl[1]  = '{0, 1, 0, 0, 32'h0, 0};
        tbl[2]  = '{0, 1, 1, 0, 32'h0800_0001, 1};
        tbl[3]  = '{0, 1, 1, 1, 32'h0800_0002, 1};
        tbl[4]  = '{0, 1, 1, 2, 32'h0800_0003, 1};
        tbl[5]  = '{0, 1, 1, 3, 32'h0800_0004, 1};
        tbl[6]  = '{0, 0, 1, 3, 32'h0800_0004, 2};
        tbl[7]  = '{0, 0, 1, 3, 32'h0800_0004, 3};
        tbl[8]  = '{0, 0, 1, 3, 32'h0800_0004, 4};
        tbl[9]  = '{0, 0, 1, 3, 32'h0800_0004, 4};
        tbl[10] = '{0, 1, 1, 4, 32'h0800_0005, 3};
        tbl[11] = '{0, 1, 1, 5, 32'h0800_0006, 2};

        sys_rst = 1; prog_we = 0; prog_addr = '0; prog_data = '0;
        start = 0; redirect_valid = 0; redirect_pc = '0; ready = 0;
        tick(); tick();
        chk("rst_valid", 32'(irb.ir_valid), 0);
        chk("rst_data", irb.ir_data, 0);
        chk("rst_pc", 32'(irb.ir_pc), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_halted", 32'(halted), 0);

        sys_rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            prog_we = 1; prog_addr = AW'(i); prog_data = 32'h0800_0001 + i;
            tick();
        end
        prog_we = 0;

        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st; ready = tbl[i].rdy;
            tick();
            start = 0;
            chk($sformatf("vec%0d_valid", i), 32'(irb.ir_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), tbl[i].ecnt);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_pc", i), 32'(irb.ir_pc), tbl[i].epc);
                chk($sformatf("vec%0d_data", i), irb.ir_data, tbl[i].edata);
            end
        end

        // backpressure from start, then drain in order
        sys_rst = 1; tick(); sys_rst = 0;
        ready = 0; start = 1; tick(); start = 0;
        repeat (8) tick();
        chk("bp_count_sat", 32'(fifo_count), 4);
        ready = 1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_pc%0d", k), 32'(irb.ir_pc), k);
            chk($sformatf("bp_data%0d", k), irb.ir_data, 32'h0800_0001 + k);
            tick();
        end

        // redirect colliding with a pop, FIFO half full
        sys_rst = 1; tick(); sys_rst = 0;
        ready = 0; start = 1; tick(); start = 0;
        repeat (3) tick();
        chk("rd_half", 32'(fifo_count), 2);
        redirect_valid = 1; redirect_pc = 4'd9; ready = 1;
        tick();
        redirect_valid = 0; ready = 0;
        chk("rd_count0", 32'(fifo_count), 0);
        chk("rd_valid_t1", 32'(irb.ir_valid), 0);
        tick();
        chk("rd_valid_t2", 32'(irb.ir_valid), 0);
        tick();
        chk("rd_valid_t3", 32'(irb.ir_valid), 1);
        chk("rd_pc_t3", 32'(irb.ir_pc), 9);
        chk("rd_data_t3", irb.ir_data, 32'h0800_000A);

        // PC wrap across the top of program memory
        ready = 1; redirect_valid = 1; redirect_pc = 4'd14;
        tick();
        redirect_valid = 0;
        tick(); tick();
        chk("wrap_data14", irb.ir_data, 32'h0800_000F);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap_pc%0d", k), 32'(irb.ir_pc), (14 + k) % 16);
            tick();
        end

        // load attempt while running must be ignored
        prog_we = 1; prog_addr = 4'd2; prog_data = 32'hDEAD_BEEF;
        tick();
        prog_we = 0;
        sys_rst = 1; tick(); sys_rst = 0;
        ready = 1; start = 1; tick(); start = 0;
        repeat (4) tick();
        chk("we_run_pc", 32'(irb.ir_pc), 2);
        chk("we_run_data", irb.ir_data, 32'h0800_0003);

`ifdef IFETCH_HALT_DET_EN
        sys_rst = 1; tick(); sys_rst = 0;
        prog_we = 1; prog_addr = 4'd2; prog_data = 32'hF800_0000;
        tick();
        prog_we = 0; ready = 1; start = 1; tick(); start = 0;
        tick(); tick();
        chk("h_pc0", 32'(irb.ir_pc), 0);
        chk("h_nohalt", 32'(halted), 0);
        tick();
        chk("h_pc1", 32'(irb.ir_pc), 1);
        tick();
        chk("h_pc2", 32'(irb.ir_pc), 2);
        chk("h_halted", 32'(halted), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("h_novalid", 32'(irb.ir_valid), 0);
        end
        chk("h_stay", 32'(halted), 1);
        redirect_valid = 1; redirect_pc = 4'd0;
        tick();
        redirect_valid = 0;
        chk("h_clear", 32'(halted), 0);
        tick(); tick();
        chk("h_resume_v", 32'(irb.ir_valid), 1);
        chk("h_resume_pc", 32'(irb.ir_pc), 0);
        sys_rst = 1; tick(); sys_rst = 0;
        prog_we = 1; prog_addr = 4'd2; prog_data = 32'h0800_0003;
        tick();
        prog_we = 0;
`endif

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sys_rst        = ($urandom % 100) == 0;
            start          = ($urandom % 10) == 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = AW'($urandom_range(0, DEPTH - 1));
            ready          = ($urandom % 4) != 0;
            prog_we        = ($urandom % 8) == 0;
            prog_addr      = AW'($urandom_range(0, DEPTH - 1));
            prog_data      = $urandom;
            tick();
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
